pwm_multi_channel: RTL and testbench

- Counter-based N-channel PWM generator. All channels share one period counter; each channel has its own duty compare.
- Duty and period are double-buffered. A `load` strobe writes shadow registers, and the shadows take effect only at a period boundary, so no runt pulses occur.
- Supports edge-aligned and center-aligned modes.
- Sits between the register/control logic and the motor/LED driver pins.

---
 rtl/pwm_multi_channel.sv | 154 +++++++++++++++
 tb/tb_pwm_multi_channel.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi_channel.sv
// pwm_multi_channel: shared-counter N-channel PWM generator.
// Period, duty and alignment mode are double-buffered. A load strobe fills the
// shadow set, and the shadow set moves into the active set only at a period
// boundary, so a running output never produces a runt pulse.
module pwm_multi_channel #(
    parameter int CNT_WIDTH = 16,
    parameter int CHANNELS  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          center_mode,
    input  logic [CNT_WIDTH-1:0]          period,
    input  logic [CHANNELS*CNT_WIDTH-1:0] duty,
    input  logic                          load,
    output logic [CHANNELS-1:0]           pwm_out,
    output logic                          period_end,
    output logic                          load_pending
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, RUN_UP, RUN_DOWN} state_t;

    state_t                          state, state_nxt;
    logic [CNT_WIDTH-1:0]            cnt, cnt_nxt;
    logic [CNT_WIDTH-1:0]            sh_period, act_period;
    logic [CHANNELS*CNT_WIDTH-1:0]   sh_duty, act_duty;
    logic                            sh_center, act_center;
    logic                            boundary;
    logic                            transfer;
    logic [CHANNELS-1:0]             pwm_nxt;
    logic                            pe_nxt;

    // Last cycle of the current period; a zero period makes every cycle a boundary.
    always_comb begin
        boundary = 1'b0;
        if (state != IDLE) begin
            if (act_period == '0)
                boundary = 1'b1;
            else if (!act_center)
                boundary = (cnt == act_period - CNT_ONE);
            else if (act_period == CNT_ONE)
                boundary = (cnt == CNT_ONE);
            else
                boundary = (state == RUN_DOWN) && (cnt == CNT_ONE);
        end
    end

    // Next state / counter, and whether the shadow set moves to active this edge.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        transfer  = 1'b0;
        if (!enable) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = RUN_UP;
                    cnt_nxt   = '0;
                    transfer  = 1'b1;
                end
                default: begin
                    if (boundary) begin
                        state_nxt = RUN_UP;
                        cnt_nxt   = '0;
                        transfer  = load_pending;
                    end else if (!act_center) begin
                        state_nxt = RUN_UP;
                        cnt_nxt   = cnt + CNT_ONE;
                    end else if (state == RUN_UP) begin
                        if (cnt == act_period) begin
                            state_nxt = RUN_DOWN;
                            cnt_nxt   = cnt - CNT_ONE;
                        end else begin
                            cnt_nxt   = cnt + CNT_ONE;
                        end
                    end else begin
                        cnt_nxt = cnt - CNT_ONE;
                    end
                end
            endcase
        end
    end

    // Per-channel compare and boundary flag, registered below so both lag the counter by one cycle.
    always_comb begin
        pwm_nxt = '0;
        pe_nxt  = 1'b0;
        if (enable && (state != IDLE) && (act_period != '0)) begin
            for (int i = 0; i < CHANNELS; i++)
                pwm_nxt[i] = (cnt < act_duty[i*CNT_WIDTH +: CNT_WIDTH]);
            pe_nxt = boundary;
        end
    end

    // State register and period counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Shadow capture on load; a load on the transfer edge wins and keeps the request pending.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_period    <= '0;
            sh_duty      <= '0;
            sh_center    <= 1'b0;
            load_pending <= 1'b0;
        end else begin
            if (load) begin
                sh_period <= period;
                sh_duty   <= duty;
                sh_center <= center_mode;
            end
            if (load)
                load_pending <= 1'b1;
            else if (transfer)
                load_pending <= 1'b0;
        end
    end

    // Active set updates atomically from the pre-load shadow contents.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            act_period <= '0;
            act_duty   <= '0;
            act_center <= 1'b0;
        end else if (transfer) begin
            act_period <= sh_period;
            act_duty   <= sh_duty;
            act_center <= sh_center;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pwm_out    <= '0;
            period_end <= 1'b0;
        end else begin
            pwm_out    <= pwm_nxt;
            period_end <= pe_nxt;
        end
    end

endmodule

// File: tb/tb_pwm_multi_channel.sv
// tb_pwm_multi_channel: directed, table-driven bench for pwm_multi_channel.
module tb_pwm_multi_channel;

    localparam int W  = 16;
    localparam int CH = 4;

    logic              clk;
    logic              reset;
    logic              enable;
    logic              center_mode;
    logic [W-1:0]      period;
    logic [CH*W-1:0]   duty;
    logic              load;
    logic [CH-1:0]     pwm_out;
    logic              period_end;
    logic              load_pending;

    pwm_multi_channel #(.CNT_WIDTH(W), .CHANNELS(CH)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .center_mode  (center_mode),
        .period       (period),
        .duty         (duty),
        .load         (load),
        .pwm_out      (pwm_out),
        .period_end   (period_end),
        .load_pending (load_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int p;
        int d0, d1, d2, d3;
        bit ctr;
        int per;
        int h0, h1, h2, h3;
    } row_t;

    int n_cmp  = 0;
    int n_fail = 0;
    int hi_cnt [CH];
    int lp_cnt, pe_cnt, last_pe, last_lp;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_inputs(input int p, input int d0, input int d1, input int d2,
                              input int d3, input bit ctr);
        period      = W'(p);
        duty        = {W'(d3), W'(d2), W'(d1), W'(d0)};
        center_mode = ctr;
    endtask

    // Stop, load a fresh configuration while idle, then enable.
    task automatic start_cfg(input int p, input int d0, input int d1, input int d2,
                             input int d3, input bit ctr);
        enable = 1'b0;
        tick();
        set_inputs(p, d0, d1, d2, d3, ctr);
        load = 1'b1;
        tick();
        load   = 1'b0;
        enable = 1'b1;
        tick();
    endtask

    task automatic wait_pe(input string name, input int bound);
        int seen;
        seen = 0;
        for (int k = 0; k < bound && seen == 0; k++) begin
            tick();
            if (period_end) seen = 1;
        end
        check(name, seen, 1);
    endtask

    // Sample one period's worth of cycles, optionally pulsing load at offset load_at.
    task automatic run_window(input int per, input int load_at);
        for (int c = 0; c < CH; c++) hi_cnt[c] = 0;
        lp_cnt = 0;
        pe_cnt = 0;
        for (int j = 0; j < per; j++) begin
            load = (j == load_at);
            tick();
            for (int c = 0; c < CH; c++) if (pwm_out[c]) hi_cnt[c]++;
            if (load_pending) lp_cnt++;
            if (period_end) pe_cnt++;
        end
        load    = 1'b0;
        last_pe = int'(period_end);
        last_lp = int'(load_pending);
    endtask

    row_t rows [6];

    initial begin
        int exp_h [CH];
        int bad_pwm, bad_pe, bad_lp, pre_pwm, pre_lp;

        // Center mode: each count value 1..P-1 occurs twice, 0 and P once.
        rows[0] = '{p:10, d0:3, d1:5, d2:0, d3:12,    ctr:1'b0, per:10, h0:3, h1:5, h2:0,  h3:10};
        rows[1] = '{p:8,  d0:4, d1:0, d2:9, d3:8,     ctr:1'b1, per:16, h0:7, h1:0, h2:16, h3:15};
        rows[2] = '{p:1,  d0:1, d1:0, d2:2, d3:1,     ctr:1'b0, per:1,  h0:1, h1:0, h2:1,  h3:1};
        rows[3] = '{p:1,  d0:1, d1:0, d2:2, d3:1,     ctr:1'b1, per:2,  h0:1, h1:0, h2:2,  h3:1};
        rows[4] = '{p:5,  d0:4, d1:1, d2:5, d3:65535, ctr:1'b0, per:5,  h0:4, h1:1, h2:5,  h3:5};
        rows[5] = '{p:3,  d0:2, d1:3, d2:4, d3:1,     ctr:1'b1, per:6,  h0:3, h1:5, h2:6,  h3:1};

        reset  = 1'b0;
        enable = 1'b0;
        load   = 1'b0;
        set_inputs(0, 0, 0, 0, 0, 1'b0);
        repeat (3) tick();
        check("reset_pwm", int'(pwm_out), 0);
        check("reset_pe", int'(period_end), 0);
        check("reset_lp", int'(load_pending), 0);
        reset = 1'b1;
        tick();

        for (int r = 0; r < 6; r++) begin
            start_cfg(rows[r].p, rows[r].d0, rows[r].d1, rows[r].d2, rows[r].d3, rows[r].ctr);
            wait_pe($sformatf("row%0d_sync", r), 3 * rows[r].per + 10);
            run_window(rows[r].per, -1);
            exp_h = '{rows[r].h0, rows[r].h1, rows[r].h2, rows[r].h3};
            for (int c = 0; c < CH; c++)
                check($sformatf("row%0d_hi%0d", r, c), hi_cnt[c], exp_h[c]);
            check($sformatf("row%0d_pe_cnt", r), pe_cnt, 1);
            check($sformatf("row%0d_pe_last", r), last_pe, 1);
        end

        // Double buffering: load mid-period takes effect only after the boundary.
        start_cfg(10, 3, 0, 0, 0, 1'b0);
        wait_pe("dbuf_sync", 40);
        set_inputs(10, 7, 0, 0, 0, 1'b0);
        run_window(10, 4);
        check("dbuf_old_hi", hi_cnt[0], 3);
        check("dbuf_lp_cnt", lp_cnt, 5);
        check("dbuf_lp_last", last_lp, 0);
        check("dbuf_pe_last", last_pe, 1);
        run_window(10, -1);
        check("dbuf_new_hi", hi_cnt[0], 7);

        // Load on the boundary cycle is deferred to the following boundary.
        set_inputs(10, 2, 0, 0, 0, 1'b0);
        run_window(10, 9);
        check("bload_hi1", hi_cnt[0], 7);
        check("bload_lp_cnt1", lp_cnt, 1);
        check("bload_lp_last1", last_lp, 1);
        run_window(10, -1);
        check("bload_hi2", hi_cnt[0], 7);
        check("bload_lp_cnt2", lp_cnt, 9);
        check("bload_lp_last2", last_lp, 0);
        check("bload_pe_last2", last_pe, 1);
        run_window(10, -1);
        check("bload_hi3", hi_cnt[0], 2);

        // Edge -> center switch lands exactly on the edge boundary.
        set_inputs(5, 3, 0, 0, 0, 1'b1);
        run_window(10, 2);
        check("msw_old_hi", hi_cnt[0], 2);
        check("msw_old_pe", last_pe, 1);
        run_window(10, -1);
        check("msw_new_hi", hi_cnt[0], 5);
        check("msw_new_pe_cnt", pe_cnt, 1);
        check("msw_new_pe_last", last_pe, 1);

        // Zero period: outputs held low, pending load applies one cycle later.
        start_cfg(0, 5, 5, 5, 5, 1'b0);
        bad_pwm = 0;
        bad_pe  = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (pwm_out != '0) bad_pwm++;
            if (period_end) bad_pe++;
        end
        check("p0_pwm", bad_pwm, 0);
        check("p0_pe", bad_pe, 0);
        set_inputs(4, 2, 0, 0, 0, 1'b0);
        load = 1'b1;
        tick();
        load = 1'b0;
        check("p0_lp_set", int'(load_pending), 1);
        tick();
        check("p0_lp_clr", int'(load_pending), 0);
        wait_pe("p0_sync", 20);
        run_window(4, -1);
        check("p0_new_hi", hi_cnt[0], 2);

        // Asynchronous reset mid-period clears everything without a clock edge.
        start_cfg(10, 6, 0, 0, 0, 1'b0);
        wait_pe("rst_sync", 40);
        repeat (3) tick();
        load = 1'b1;
        tick();
        load = 1'b0;
        pre_pwm = int'(pwm_out[0]);
        pre_lp  = int'(load_pending);
        check("rst_pre_pwm", pre_pwm, 1);
        check("rst_pre_lp", pre_lp, 1);
        #2;
        reset = 1'b0;
        #1;
        check("rst_pwm", int'(pwm_out), 0);
        check("rst_pe", int'(period_end), 0);
        check("rst_lp", int'(load_pending), 0);
        tick();
        reset  = 1'b1;
        enable = 1'b1;
        bad_pwm = 0;
        bad_pe  = 0;
        bad_lp  = 0;
        for (int k = 0; k < 25; k++) begin
            tick();
            if (pwm_out != '0) bad_pwm++;
            if (period_end) bad_pe++;
            if (load_pending) bad_lp++;
        end
        check("postrst_pwm", bad_pwm, 0);
        check("postrst_pe", bad_pe, 0);
        check("postrst_lp", bad_lp, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
